// File: rtl/button_event_scheduler.sv
// Button front end: sync, edge detect and auto-repeat feed a round-robin arbiter into a small event FIFO.
// Press reaches ev_valid 3 edges after s1 captures it; while the consumer stalls, events queue, then coalesce in pending and bump drop_cnt.
module button_event_scheduler #(
  parameter int NUM_BTN       = 5,
  parameter int REPEAT_DELAY  = 3125000,
  parameter int REPEAT_PERIOD = 625000,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic               clk_oled,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic               ev_ready,
  output logic               ev_valid,
  output logic [2:0]         ev_btn,
  output logic               ev_repeat,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [7:0]         drop_cnt
);

  localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CW      = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
  localparam int AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DELAY_LAST  = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PERIOD_LAST = CW'(REPEAT_PERIOD - 1);
  localparam logic [2:0]    LAST_BTN    = 3'(NUM_BTN - 1);
  localparam logic [AW:0]   FIFO_FULL   = (AW + 1)'(FIFO_DEPTH);

  typedef struct packed {
    logic       rpt;
    logic [2:0] btn;
  } ev_t;

  logic [NUM_BTN-1:0] s1, s2, s3;
  logic [NUM_BTN-1:0] rise, rpt_ev, new_ev, drop_vec;
  logic [NUM_BTN-1:0] pend, pend_flag, phase, gnt_oh;
  logic [CW-1:0]      hold_cnt [NUM_BTN];
  logic [2:0]         rr_ptr, gnt_idx;
  logic               gnt_any, grant, pop;
  logic [8:0]         drop_sum;
  ev_t                mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [AW:0]        count;

  function automatic logic [2:0] wrap_idx(input logic [2:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NUM_BTN) s = s - NUM_BTN;
    return s[2:0];
  endfunction

  assign rise      = s2 & ~s3;
  assign new_ev    = rise | rpt_ev;
  assign btn_level = s2;
  assign ev_valid  = (count != '0);
  assign ev_btn    = mem[rd_ptr].btn;
  assign ev_repeat = mem[rd_ptr].rpt;
  assign pop       = ev_valid & ev_ready;
  assign grant     = gnt_any & (count < FIFO_FULL);

  always_comb begin
    for (int i = 0; i < NUM_BTN; i++) begin
      rpt_ev[i] = s2[i] & (phase[i] ? (hold_cnt[i] == PERIOD_LAST)
                                    : (hold_cnt[i] == DELAY_LAST));
    end
  end

  // First pending button at or after rr_ptr, wrapping around the button set.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int off = 0; off < NUM_BTN; off++) begin
      if (!gnt_any && pend[wrap_idx(rr_ptr, off)]) begin
        gnt_any = 1'b1;
        gnt_idx = wrap_idx(rr_ptr, off);
      end
    end
  end

  // A new event landing on the button being granted this cycle re-arms it rather than dropping.
  always_comb begin
    gnt_oh = '0;
    if (grant) gnt_oh[gnt_idx] = 1'b1;
    drop_vec = new_ev & pend & ~gnt_oh;
    drop_sum = {1'b0, drop_cnt} + 9'($countones(drop_vec));
  end

  always_ff @(posedge clk_oled or posedge reset) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      phase     <= '0;
      pend      <= '0;
      pend_flag <= '0;
      drop_cnt  <= '0;
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      for (int i = 0; i < NUM_BTN; i++) hold_cnt[i] <= '0;
      for (int j = 0; j < FIFO_DEPTH; j++) mem[j] <= '0;
    end else begin
      s1 <= btn_raw;
      s2 <= s1;
      s3 <= s2;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (!s2[i]) begin
          hold_cnt[i] <= '0;
          phase[i]    <= 1'b0;
        end else if (rpt_ev[i]) begin
          hold_cnt[i] <= '0;
          phase[i]    <= 1'b1;
        end else begin
          hold_cnt[i] <= hold_cnt[i] + 1'b1;
        end
      end
      pend      <= (pend & ~gnt_oh) | new_ev;
      pend_flag <= (pend_flag & ~new_ev) | (rpt_ev & new_ev);
      drop_cnt  <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
      if (grant) begin
        mem[wr_ptr] <= '{rpt: pend_flag[gnt_idx], btn: gnt_idx};
        wr_ptr      <= wr_ptr + 1'b1;
        rr_ptr      <= (gnt_idx == LAST_BTN) ? 3'd0 : gnt_idx + 3'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({grant, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_scheduler.sv
// Directed bench for button_event_scheduler; a negedge monitor scores every accepted event against a queue.
module tb_button_event_scheduler;
  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] btn_raw;
  logic       ev_ready;
  logic       ev_valid;
  logic [2:0] ev_btn;
  logic       ev_repeat;
  logic [4:0] btn_level;
  logic [7:0] drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  button_event_scheduler #(
    .NUM_BTN(5), .REPEAT_DELAY(8), .REPEAT_PERIOD(4), .FIFO_DEPTH(4)
  ) dut (
    .clk_oled(clk), .reset(reset), .btn_raw(btn_raw), .ev_ready(ev_ready),
    .ev_valid(ev_valid), .ev_btn(ev_btn), .ev_repeat(ev_repeat),
    .btn_level(btn_level), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && ev_valid && ev_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: got btn=%0d rpt=%0b want none", ev_btn, ev_repeat);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        chk("event", {28'd0, ev_repeat, ev_btn}, {28'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [2:0] b, input logic r);
    exp_q.push_back({r, b});
  endtask

  task automatic tap(input logic [4:0] b);
    btn_raw = b;
    step();
    btn_raw = '0;
    step();
  endtask

  task automatic drain(input int max_cyc);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      step();
      n++;
    end
    chk("drain_left", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running want finished");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    btn_raw  = '0;
    ev_ready = 1'b0;
    step();
    step();
    chk("rst_valid", ev_valid, 0);
    chk("rst_btn", ev_btn, 0);
    chk("rst_rpt", ev_repeat, 0);
    chk("rst_level", btn_level, 0);
    chk("rst_drop", drop_cnt, 0);
    #3 reset = 1'b0;

    // Hold button 0 for 18 edges: one press plus repeats pushed at k+10, k+14, k+18.
    ev_ready = 1'b1;
    step();
    btn_raw = 5'b00001;
    push(0, 0); push(0, 1); push(0, 1); push(0, 1);
    step(); step(); step();
    chk("hold_pre_lat", ev_valid, 0);
    step();
    chk("hold_first", {ev_valid, ev_repeat, ev_btn}, {1'b1, 1'b0, 3'd0});
    step();
    chk("hold_pulse_end", ev_valid, 0);
    repeat (5) step();
    chk("hold_rpt_pre", ev_valid, 0);
    step();
    chk("hold_rpt1", {ev_valid, ev_repeat, ev_btn}, {1'b1, 1'b1, 3'd0});
    repeat (7) step();
    btn_raw = '0;
    drain(30);
    repeat (20) step();
    chk("hold_level_off", btn_level, 0);

    // Simultaneous 1,2,4 served round-robin on consecutive cycles.
    step();
    btn_raw = 5'b10110;
    push(1, 0); push(2, 0); push(4, 0);
    step();
    btn_raw = '0;
    step(); step(); step();
    chk("rr_first", {ev_valid, ev_btn}, {1'b1, 3'd1});
    step();
    chk("rr_second", {ev_valid, ev_btn}, {1'b1, 3'd2});
    step();
    chk("rr_third", {ev_valid, ev_btn}, {1'b1, 3'd4});
    step();
    chk("rr_idle", ev_valid, 0);
    btn_raw = 5'b10001;
    push(0, 0); push(4, 0);
    step();
    btn_raw = '0;
    drain(20);

    // Stalled consumer: FIFO fills with 0..3, button 4 coalesces once.
    ev_ready = 1'b0;
    tap(5'b00001); tap(5'b00010); tap(5'b00100); tap(5'b01000);
    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    tap(5'b10000); tap(5'b10000);
    repeat (4) step();
    chk("full_drop", drop_cnt, 1);
    chk("full_head", {ev_valid, ev_btn}, {1'b1, 3'd0});
    ev_ready = 1'b1;
    drain(30);

    // Head stays stable under backpressure; then a pop and push coincide.
    ev_ready = 1'b0;
    push(1, 0);
    tap(5'b00010);
    repeat (3) step();
    for (int i = 0; i < 20; i++) begin
      chk("stall_stable", {ev_valid, ev_repeat, ev_btn}, {1'b1, 1'b0, 3'd1});
      step();
    end
    push(2, 0);
    btn_raw = 5'b00100;
    step();
    btn_raw = '0;
    step(); step();
    ev_ready = 1'b1;
    step();
    chk("popush_head", {ev_valid, ev_btn}, {1'b1, 3'd2});
    step();
    chk("popush_empty", ev_valid, 0);

    // Asynchronous reset with 3 queued and button 3 pending.
    ev_ready = 1'b0;
    tap(5'b00001); tap(5'b00010); tap(5'b00100);
    btn_raw = 5'b01000;
    step(); step(); step();
    #3;
    chk("prerst_level", btn_level, 5'b01000);
    chk("prerst_valid", ev_valid, 1);
    reset = 1'b1;
    #1;
    chk("arst_valid", ev_valid, 0);
    chk("arst_drop", drop_cnt, 0);
    chk("arst_level", btn_level, 0);
    chk("arst_btn", ev_btn, 0);
    exp_q.delete();
    btn_raw = '0;
    step(); step();
    #3 reset = 1'b0;
    ev_ready = 1'b1;
    repeat (20) step();
    chk("postrst_idle", ev_valid, 0);

    // 300 coalesced taps on button 4 with the FIFO full.
    ev_ready = 1'b0;
    tap(5'b00001); tap(5'b00010); tap(5'b00100); tap(5'b01000);
    push(0, 0); push(1, 0); push(2, 0); push(3, 0); push(4, 0);
    repeat (101) tap(5'b10000);
    repeat (3) step();
    chk("drop_100", drop_cnt, 100);
    repeat (200) tap(5'b10000);
    repeat (3) step();
    chk("drop_sat", drop_cnt, 255);
    chk("sat_head", {ev_valid, ev_btn}, {1'b1, 3'd0});
    ev_ready = 1'b1;
    drain(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
